// File: rtl/eb1_pkg.sv
// Shared constants and types for the decode-stage integer register bank.
package eb1_pkg;

    localparam int EB1_GPR_CNT_W = 16;
    localparam int EB1_GPR_NREGS = 32;
    localparam int EB1_GPR_AW    = $clog2(EB1_GPR_NREGS);

    // Scoreboard-side view of a write port: enable plus destination register.
    typedef struct packed {
        logic                  wen;
        logic [EB1_GPR_AW-1:0] waddr;
    } eb1_sb_wr_t;

endpackage

// File: rtl/eb1_dec_gpr_wr_arb.sv
// Per-register write-port priority select. For every register 1..NREGS-1 picks
// the highest-index enabled port addressing it and flags multi-port hits.
// Register 0 never takes a write.
module eb1_dec_gpr_wr_arb #(
    parameter int NREGS = 32,
    parameter int XLEN  = 32,
    parameter int NWR   = 3,
    localparam int AW   = $clog2(NREGS)
) (
    input  logic [NWR-1:0]              wen,
    input  logic [NWR-1:0][AW-1:0]      waddr,
    input  logic [NWR-1:0][XLEN-1:0]    wd,
    output logic [NREGS-1:0]            we,
    output logic [NREGS-1:0][XLEN-1:0]  wsel,
    output logic [NREGS-1:0]            multi
);

    assign we[0]    = 1'b0;
    assign wsel[0]  = '0;
    assign multi[0] = 1'b0;

    for (genvar g = 1; g < NREGS; g++) begin : g_reg
        localparam logic [AW-1:0] IDX = AW'(g);
        logic            hit;
        logic [XLEN-1:0] dat;
        logic            dup;

        // Later (higher-index) ports overwrite earlier ones; a hit after a hit is a collision.
        always_comb begin
            hit = 1'b0;
            dat = '0;
            dup = 1'b0;
            for (int p = 0; p < NWR; p++) begin
                if (wen[p] && (waddr[p] == IDX)) begin
                    dup = dup | hit;
                    hit = 1'b1;
                    dat = wd[p];
                end
            end
        end

        assign we[g]    = hit;
        assign wsel[g]  = dat;
        assign multi[g] = dup;
    end

endmodule

// File: rtl/eb1_dec_gpr_bank.sv
// Multi-port integer register file with busy scoreboard, optional write-to-read
// bypass and write-collision tracking.
module eb1_dec_gpr_bank
    import eb1_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int XLEN   = 32,
    parameter int NRD    = 2,
    parameter int NWR    = 3,
    parameter int BYPASS = 1,
    localparam int AW    = $clog2(NREGS)
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NRD-1:0][AW-1:0]       raddr,
    output logic [NRD-1:0][XLEN-1:0]     rd,
    output logic [NRD-1:0]               rd_busy,
    input  logic [NWR-1:0]               wen,
    input  logic [NWR-1:0][AW-1:0]       waddr,
    input  logic [NWR-1:0][XLEN-1:0]     wd,
    input  logic                         issue_vld,
    input  logic [AW-1:0]                issue_addr,
    input  logic                         flush,
    output logic                         wr_collision,
    output logic [EB1_GPR_CNT_W-1:0]     collision_cnt
);

    localparam logic [EB1_GPR_CNT_W-1:0] CNT_MAX = '1;

    logic [NREGS-1:0][XLEN-1:0] regs;
    logic [NREGS-1:0]           busy;
    logic [NREGS-1:0]           we;
    logic [NREGS-1:0][XLEN-1:0] wsel;
    logic [NREGS-1:0]           multi;
    logic                       any_multi;

    eb1_dec_gpr_wr_arb #(
        .NREGS (NREGS),
        .XLEN  (XLEN),
        .NWR   (NWR)
    ) u_arb (
        .wen   (wen),
        .waddr (waddr),
        .wd    (wd),
        .we    (we),
        .wsel  (wsel),
        .multi (multi)
    );

    assign any_multi = |multi;

    // Register storage; entry 0 is only ever reset so it stays zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            regs <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (we[i]) regs[i] <= wsel[i];
            end
        end
    end

    // Scoreboard: flush beats issue, issue beats writeback (new producer wins).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy <= '0;
        end else if (flush) begin
            busy <= '0;
        end else begin
            for (int i = 1; i < NREGS; i++) begin
                if (issue_vld && (issue_addr == AW'(i))) busy[i] <= 1'b1;
                else if (we[i])                          busy[i] <= 1'b0;
            end
        end
    end

    // Collision flag for last cycle and a saturating count of colliding cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_collision  <= 1'b0;
            collision_cnt <= '0;
        end else begin
            wr_collision <= any_multi;
            if (any_multi && (collision_cnt != CNT_MAX))
                collision_cnt <= collision_cnt + EB1_GPR_CNT_W'(1);
        end
    end

    // Read ports: AND-OR select over stored regs, then forward the winning write if bypassing.
    always_comb begin
        rd      = '0;
        rd_busy = '0;
        for (int r = 0; r < NRD; r++) begin
            for (int i = 0; i < NREGS; i++) begin
                rd[r] = rd[r] | (regs[i] & {XLEN{raddr[r] == AW'(i)}});
            end
            rd_busy[r] = busy[raddr[r]];
            if ((BYPASS != 0) && we[raddr[r]]) begin
                rd[r]      = wsel[raddr[r]];
                rd_busy[r] = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_eb1_dec_gpr_bank.sv
// Directed bench for eb1_dec_gpr_bank: a bypassing and a non-bypassing
// instance driven by identical stimulus.
module tb_eb1_dec_gpr_bank;

    logic             clk;
    logic             rst;
    logic [1:0][4:0]  raddr;
    logic [2:0]       wen;
    logic [2:0][4:0]  waddr;
    logic [2:0][31:0] wd;
    logic             issue_vld;
    logic [4:0]       issue_addr;
    logic             flush;

    logic [1:0][31:0] rd_b, rd_n;
    logic [1:0]       bsy_b, bsy_n;
    logic             coll_b, coll_n;
    logic [15:0]      cnt_b, cnt_n;

    int n_checks = 0;
    int n_fail   = 0;

    eb1_dec_gpr_bank #(.BYPASS(1)) u_byp (
        .clk(clk), .rst(rst), .raddr(raddr), .rd(rd_b), .rd_busy(bsy_b),
        .wen(wen), .waddr(waddr), .wd(wd), .issue_vld(issue_vld),
        .issue_addr(issue_addr), .flush(flush),
        .wr_collision(coll_b), .collision_cnt(cnt_b)
    );

    eb1_dec_gpr_bank #(.BYPASS(0)) u_nob (
        .clk(clk), .rst(rst), .raddr(raddr), .rd(rd_n), .rd_busy(bsy_n),
        .wen(wen), .waddr(waddr), .wd(wd), .issue_vld(issue_vld),
        .issue_addr(issue_addr), .flush(flush),
        .wr_collision(coll_n), .collision_cnt(cnt_n)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen       = '0;
        issue_vld = 1'b0;
        flush     = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); raddr = '{5'd0, 5'd5}; waddr = '0; wd = '0; issue_addr = '0;
        step(); step();
        rst = 1'b0;
        #1;
        n_checks++; if (cnt_b !== 16'h0) begin n_fail++; $display("FAIL reset_cnt got %h want 0000", cnt_b); end
        n_checks++; if (coll_b !== 1'b0) begin n_fail++; $display("FAIL reset_coll got %b want 0", coll_b); end
        n_checks++; if (rd_b[0] !== 32'h0) begin n_fail++; $display("FAIL reset_rd got %h want 0", rd_b[0]); end
        // write x5, then collide on x8 and issue x5, then pulse reset
        wen = 3'b001; waddr[0] = 5'd5; wd[0] = 32'hDEAD;
        step(); idle(); #1;
        n_checks++; if (rd_n[0] !== 32'hDEAD) begin n_fail++; $display("FAIL wr_x5 got %h want 0000dead", rd_n[0]); end
        wen = 3'b011; waddr[0] = 5'd8; waddr[1] = 5'd8; issue_vld = 1'b1; issue_addr = 5'd5;
        step(); idle(); #1;
        n_checks++; if (cnt_b !== 16'h1 || bsy_b[0] !== 1'b1) begin n_fail++; $display("FAIL pre_rst got cnt=%h busy=%b want 0001/1", cnt_b, bsy_b[0]); end
        rst = 1'b1; #2;
        n_checks++; if (rd_b[0] !== 32'h0 || rd_n[0] !== 32'h0) begin n_fail++; $display("FAIL rst_rd got %h/%h want 0", rd_b[0], rd_n[0]); end
        n_checks++; if (bsy_b !== 2'b00 || bsy_n !== 2'b00) begin n_fail++; $display("FAIL rst_busy got %b/%b want 00", bsy_b, bsy_n); end
        n_checks++; if (cnt_b !== 16'h0 || coll_b !== 1'b0) begin n_fail++; $display("FAIL rst_cnt got cnt=%h coll=%b want 0000/0", cnt_b, coll_b); end
        rst = 1'b0;
    endtask

    task automatic test_collision();
        raddr[0] = 5'd7;
        wen = 3'b111; waddr = '{5'd7, 5'd7, 5'd7}; wd = '{32'd3, 32'd2, 32'd1};
        #1;
        n_checks++; if (rd_b[0] !== 32'd3) begin n_fail++; $display("FAIL coll_bypass got %h want 3", rd_b[0]); end
        step(); idle(); #1;
        n_checks++; if (rd_n[0] !== 32'd3) begin n_fail++; $display("FAIL coll_data got %h want 3", rd_n[0]); end
        n_checks++; if (coll_b !== 1'b1 || cnt_b !== 16'd1) begin n_fail++; $display("FAIL coll_flag got coll=%b cnt=%h want 1/0001", coll_b, cnt_b); end
        step();
        n_checks++; if (coll_b !== 1'b0 || cnt_b !== 16'd1) begin n_fail++; $display("FAIL coll_clear got coll=%b cnt=%h want 0/0001", coll_b, cnt_b); end
        // two ports to different regs: no collision
        wen = 3'b101; waddr[0] = 5'd11; waddr[2] = 5'd12;
        step(); idle(); #1;
        n_checks++; if (coll_b !== 1'b0 || cnt_b !== 16'd1) begin n_fail++; $display("FAIL no_coll got coll=%b cnt=%h want 0/0001", coll_b, cnt_b); end
    endtask

    task automatic test_bypass();
        raddr[0] = 5'd9;
        wen = 3'b001; waddr[0] = 5'd9; wd[0] = 32'h1111;
        step(); idle();
        issue_vld = 1'b1; issue_addr = 5'd9;
        step(); idle();
        wen = 3'b010; waddr[1] = 5'd9; wd[1] = 32'hA5A5;
        #1;
        n_checks++; if (rd_b[0] !== 32'hA5A5 || bsy_b[0] !== 1'b0) begin n_fail++; $display("FAIL byp_on got %h busy=%b want 0000a5a5/0", rd_b[0], bsy_b[0]); end
        n_checks++; if (rd_n[0] !== 32'h1111 || bsy_n[0] !== 1'b1) begin n_fail++; $display("FAIL byp_off got %h busy=%b want 00001111/1", rd_n[0], bsy_n[0]); end
        step(); idle(); #1;
        n_checks++; if (rd_n[0] !== 32'hA5A5 || bsy_n[0] !== 1'b0) begin n_fail++; $display("FAIL byp_after got %h busy=%b want 0000a5a5/0", rd_n[0], bsy_n[0]); end
        // bypass takes the higher-priority port
        wen = 3'b101; waddr[0] = 5'd9; waddr[2] = 5'd9; wd[0] = 32'h0BAD; wd[2] = 32'h600D;
        #1;
        n_checks++; if (rd_b[0] !== 32'h600D) begin n_fail++; $display("FAIL byp_prio got %h want 0000600d", rd_b[0]); end
        step(); idle();
    endtask

    task automatic test_scoreboard();
        raddr[1] = 5'd3;
        issue_vld = 1'b1; issue_addr = 5'd3;
        #1;
        n_checks++; if (bsy_b[1] !== 1'b0) begin n_fail++; $display("FAIL sb_pre got %b want 0", bsy_b[1]); end
        step(); idle(); #1;
        n_checks++; if (bsy_b[1] !== 1'b1 || bsy_n[1] !== 1'b1) begin n_fail++; $display("FAIL sb_issue got %b/%b want 1/1", bsy_b[1], bsy_n[1]); end
        wen = 3'b100; waddr[2] = 5'd3; wd[2] = 32'h33;
        step(); idle(); #1;
        n_checks++; if (bsy_n[1] !== 1'b0 || rd_n[1] !== 32'h33) begin n_fail++; $display("FAIL sb_wb got busy=%b rd=%h want 0/00000033", bsy_n[1], rd_n[1]); end
        issue_vld = 1'b1; issue_addr = 5'd3; wen = 3'b001; waddr[0] = 5'd3; wd[0] = 32'h44;
        step(); idle(); #1;
        n_checks++; if (bsy_n[1] !== 1'b1 || rd_n[1] !== 32'h44) begin n_fail++; $display("FAIL sb_iss_wr got busy=%b rd=%h want 1/00000044", bsy_n[1], rd_n[1]); end
    endtask

    task automatic test_flush();
        for (int r = 1; r <= 4; r++) begin
            issue_vld = 1'b1; issue_addr = 5'(r);
            step();
        end
        idle(); raddr = '{5'd4, 5'd1}; #1;
        n_checks++; if (bsy_n !== 2'b11) begin n_fail++; $display("FAIL fl_pre got %b want 11", bsy_n); end
        flush = 1'b1; issue_vld = 1'b1; issue_addr = 5'd6;
        step(); idle(); #1;
        n_checks++; if (bsy_n !== 2'b00) begin n_fail++; $display("FAIL fl_x1x4 got %b want 00", bsy_n); end
        raddr = '{5'd0, 5'd6}; #1;
        n_checks++; if (bsy_n[0] !== 1'b0) begin n_fail++; $display("FAIL fl_x6 got %b want 0", bsy_n[0]); end
        // x0 writes and issue are ignored and never collide
        wen = 3'b111; waddr = '0; wd = '{32'h7, 32'h8, 32'h9}; issue_vld = 1'b1; issue_addr = 5'd0;
        #1;
        n_checks++; if (rd_b[1] !== 32'h0 || bsy_b[1] !== 1'b0) begin n_fail++; $display("FAIL x0_byp got %h busy=%b want 0/0", rd_b[1], bsy_b[1]); end
        step(); idle(); #1;
        n_checks++; if (rd_n[1] !== 32'h0 || bsy_n[1] !== 1'b0 || coll_n !== 1'b0) begin n_fail++; $display("FAIL x0_wr got %h busy=%b coll=%b want 0/0/0", rd_n[1], bsy_n[1], coll_n); end
    endtask

    task automatic test_saturation();
        rst = 1'b1; #2; rst = 1'b0;
        wen = 3'b011; waddr = '{5'd10, 5'd10, 5'd10};
        for (int k = 0; k < 65534; k++) step();
        n_checks++; if (cnt_b !== 16'hFFFE) begin n_fail++; $display("FAIL sat_fffe got %h want fffe", cnt_b); end
        step();
        n_checks++; if (cnt_b !== 16'hFFFF) begin n_fail++; $display("FAIL sat_ffff got %h want ffff", cnt_b); end
        step();
        n_checks++; if (cnt_b !== 16'hFFFF || cnt_n !== 16'hFFFF) begin n_fail++; $display("FAIL sat_hold got %h/%h want ffff", cnt_b, cnt_n); end
        idle();
    endtask

    initial begin
        test_reset();
        test_collision();
        test_bypass();
        test_scoreboard();
        test_flush();
        test_saturation();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
